// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter sequencing instruction fetch and data access for a multicycle CPU.
// Define ARB_TIMEOUT_EN to add the ack-timeout watchdog (HALT state, sticky err).
module unified_mem_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [31:0]       iaddr,
  input  logic [31:0]       daddr,
  input  logic [DATA_W-1:0] ddata_w,
  input  logic              d_rw,
  input  logic              d_req,
  output logic [DATA_W-1:0] idata,
  output logic [DATA_W-1:0] ddata_r,
  output logic              cpu_en,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       instr_count,
  output logic              err
);

  localparam int unsigned CNT_W = 32;
  localparam logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    COMMIT = 2'd2
`ifdef ARB_TIMEOUT_EN
    , HALT = 2'd3
`endif
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               data_done;
  logic [CNT_W-1:0]   count_q;
  logic               req_phase;
  logic               take_instr;
  logic               take_data;
  logic               retire;
  logic               halt_hit;

  assign req_phase   = (state == FETCH) || (state == DATA);
  assign instr_count = count_q;

  // Memory request drives; forced idle while reset is asserted.
  assign mem_req   = RESET_N & req_phase;
  assign mem_we    = RESET_N & (state == DATA) & d_rw;
  assign mem_addr  = (state == DATA) ? daddr : iaddr;
  assign mem_wdata = (state == DATA) ? ddata_w : '0;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;

  assign halt_hit = req_phase && !mem_ack && (tmo_cnt == 8'd254);
  assign err      = err_q;

  // Counts unacknowledged request cycles; the 255th one trips HALT.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_cnt <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      if (req_phase && mem_ack) begin
        tmo_cnt <= 8'd0;
      end else if (req_phase && (tmo_cnt != 8'hFF)) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (halt_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign halt_hit = 1'b0;
  assign err      = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; mem_ack only matters in the two request states.
  always_comb begin
    next_state = state;
    take_instr = 1'b0;
    take_data  = 1'b0;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        if (mem_ack) begin
          take_instr = 1'b1;
          next_state = COMMIT;
        end
      end
      DATA: begin
        if (mem_ack) begin
          take_data  = 1'b1;
          next_state = COMMIT;
        end
      end
      COMMIT: begin
        if (d_req && !data_done) begin
          next_state = DATA;
        end else begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
`ifdef ARB_TIMEOUT_EN
      HALT: begin
        next_state = HALT;
      end
`endif
      default: begin
        next_state = FETCH;
      end
    endcase
    if (halt_hit) begin
`ifdef ARB_TIMEOUT_EN
      next_state = HALT;
`endif
      take_instr = 1'b0;
      take_data  = 1'b0;
    end
  end

  // Datapath registers and the retire pulse/counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idata     <= NOP_INSTR;
      ddata_r   <= '0;
      cpu_en    <= 1'b0;
      data_done <= 1'b0;
      count_q   <= '0;
    end else begin
      cpu_en <= retire;
      if (take_instr) begin
        idata <= mem_rdata;
      end
      if (take_data && !d_rw) begin
        ddata_r <= mem_rdata;
      end
      if (retire || cpu_en) begin
        data_done <= 1'b0;
      end else if (take_data) begin
        data_done <= 1'b1;
      end
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter: ALU, load, store, reset abort, timeout, counter wrap.
module tb_unified_mem_arbiter;

  logic        CLK;
  logic        RESET_N;
  logic [31:0] iaddr;
  logic [31:0] daddr;
  logic [31:0] ddata_w;
  logic        d_rw;
  logic        d_req;
  logic [31:0] idata;
  logic [31:0] ddata_r;
  logic        cpu_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr_count;
  logic        err;

  int checks;
  int failures;

  unified_mem_arbiter #(.DATA_W(32)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .iaddr       (iaddr),
    .daddr       (daddr),
    .ddata_w     (ddata_w),
    .d_rw        (d_rw),
    .d_req       (d_req),
    .idata       (idata),
    .ddata_r     (ddata_r),
    .cpu_en      (cpu_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_count (instr_count),
    .err         (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET_N  = 1'b0;
    iaddr    = 32'h0;
    daddr    = 32'h0;
    ddata_w  = 32'h0;
    d_rw     = 1'b0;
    d_req    = 1'b0;
    mem_ack  = 1'b0;
    mem_rdata = 32'h0;
    #12;
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_idata", idata, 32'h0000_0013);
    check_val("rst_ddata_r", ddata_r, 32'h0);
    check_val("rst_cpu_en", 32'(cpu_en), 32'd0);
    check_val("rst_count", instr_count, 32'h0);
    check_val("rst_err", 32'(err), 32'd0);

    // ALU instruction acked on the first fetch cycle.
    mem_ack   = 1'b1;
    mem_rdata = 32'h0050_0093;
    RESET_N   = 1'b1;
    #1;
    check_val("alu_fetch_req", 32'(mem_req), 32'd1);
    check_val("alu_fetch_addr", mem_addr, 32'h0);
    check_val("alu_fetch_we", 32'(mem_we), 32'd0);
    step();
    mem_ack = 1'b0;
    check_val("alu_idata", idata, 32'h0050_0093);
    check_val("alu_commit_req", 32'(mem_req), 32'd0);
    check_val("alu_commit_en", 32'(cpu_en), 32'd0);
    step();
    check_val("alu_cpu_en", 32'(cpu_en), 32'd1);
    check_val("alu_count", instr_count, 32'd1);
    step();
    check_val("alu_en_drop", 32'(cpu_en), 32'd0);
    check_val("alu_count_hold", instr_count, 32'd1);

    // Load from 0x100.
    iaddr = 32'h4; d_req = 1'b1; d_rw = 1'b0; daddr = 32'h100;
    mem_ack = 1'b1; mem_rdata = 32'h0000_2083;
    step();
    mem_ack = 1'b0;
    check_val("ld_idata", idata, 32'h0000_2083);
    check_val("ld_decide_en", 32'(cpu_en), 32'd0);
    check_val("ld_decide_req", 32'(mem_req), 32'd0);
    step();
    check_val("ld_data_req", 32'(mem_req), 32'd1);
    check_val("ld_data_addr", mem_addr, 32'h100);
    check_val("ld_data_we", 32'(mem_we), 32'd0);
    check_val("ld_data_en", 32'(cpu_en), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    check_val("ld_ddata_r", ddata_r, 32'hDEAD_BEEF);
    check_val("ld_commit_en", 32'(cpu_en), 32'd0);
    step();
    check_val("ld_cpu_en", 32'(cpu_en), 32'd1);
    check_val("ld_count", instr_count, 32'd2);
    check_val("ld_next_fetch_addr", mem_addr, 32'h4);

    // Store to 0x200 with the data ack delayed three cycles.
    iaddr = 32'h8; d_rw = 1'b1; daddr = 32'h200; ddata_w = 32'h1234_5678;
    mem_ack = 1'b1; mem_rdata = 32'h0011_2023;
    step();
    mem_ack = 1'b0;
    check_val("st_decide_we", 32'(mem_we), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check_val("st_we", 32'(mem_we), 32'd1);
      check_val("st_wdata", mem_wdata, 32'h1234_5678);
      check_val("st_addr", mem_addr, 32'h200);
      check_val("st_wait_en", 32'(cpu_en), 32'd0);
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    check_val("st_ddata_r_kept", ddata_r, 32'hDEAD_BEEF);
    check_val("st_commit_en", 32'(cpu_en), 32'd0);
    step();
    check_val("st_cpu_en", 32'(cpu_en), 32'd1);
    check_val("st_count", instr_count, 32'd3);
    step();
    check_val("st_single_pulse", 32'(cpu_en), 32'd0);
    check_val("st_fetch_we", 32'(mem_we), 32'd0);

    // Reset asserted in the middle of a store data phase.
    iaddr = 32'hC; mem_ack = 1'b1; mem_rdata = 32'h0011_2023;
    step();
    mem_ack = 1'b0;
    step();
    check_val("rab_pre_we", 32'(mem_we), 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    check_val("rab_req", 32'(mem_req), 32'd0);
    check_val("rab_we", 32'(mem_we), 32'd0);
    check_val("rab_idata", idata, 32'h0000_0013);
    check_val("rab_count", instr_count, 32'h0);
    check_val("rab_ddata_r", ddata_r, 32'h0);
    iaddr = 32'h40; d_req = 1'b0; d_rw = 1'b0;
    #2;
    RESET_N = 1'b1;
    #1;
    check_val("rab_restart_req", 32'(mem_req), 32'd1);
    check_val("rab_restart_addr", mem_addr, 32'h40);
    check_val("rab_restart_we", 32'(mem_we), 32'd0);

    // Fetch never acknowledged.
`ifdef ARB_TIMEOUT_EN
    repeat (254) step();
    check_val("tmo_254_req", 32'(mem_req), 32'd1);
    check_val("tmo_254_err", 32'(err), 32'd0);
    step();
    check_val("tmo_err", 32'(err), 32'd1);
    check_val("tmo_req", 32'(mem_req), 32'd0);
    check_val("tmo_en", 32'(cpu_en), 32'd0);
    mem_ack = 1'b1;
    repeat (5) step();
    mem_ack = 1'b0;
    check_val("tmo_halt_req", 32'(mem_req), 32'd0);
    check_val("tmo_halt_en", 32'(cpu_en), 32'd0);
    check_val("tmo_halt_err", 32'(err), 32'd1);
`else
    repeat (300) step();
    check_val("notmo_req", 32'(mem_req), 32'd1);
    check_val("notmo_err", 32'(err), 32'd0);
    check_val("notmo_en", 32'(cpu_en), 32'd0);
`endif

    // Counter wrap via backdoor preload.
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
    #1;
    dut.count_q = 32'hFFFF_FFFF;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013; d_req = 1'b0;
    step();
    mem_ack = 1'b0;
    check_val("wrap_pre_en", 32'(cpu_en), 32'd0);
    check_val("wrap_pre_count", instr_count, 32'hFFFF_FFFF);
    step();
    check_val("wrap_en", 32'(cpu_en), 32'd1);
    check_val("wrap_count", instr_count, 32'h0);
    check_val("wrap_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
